cam_request_scheduler: RTL and testbench

CAM_REQUEST_SCHEDULER -- requirements
Module: cam_request_scheduler

---
 rtl/cam_pkg.sv | 25 ++
 rtl/cam_req_fifo.sv | 45 ++++
 rtl/cam_request_scheduler.sv | 115 +++++++++++
 tb/tb_cam_request_scheduler.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_pkg.sv
// Shared encodings, widths and FSM state constants for the CAM request scheduler.
package cam_pkg;

    localparam int DATA_W         = 8;
    localparam int ADDR_W         = 4;
    localparam int FIFO_DEPTH_DEF = 4;

    localparam logic OP_WRITE  = 1'b0;
    localparam logic OP_SEARCH = 1'b1;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_WRITE   = 3'd1;
    localparam state_t ST_SEARCH  = 3'd2;
    localparam state_t ST_CAPTURE = 3'd3;
    localparam state_t ST_RESP    = 3'd4;

    typedef struct packed {
        logic              op;
        logic [DATA_W-1:0] data;
        logic [ADDR_W-1:0] addr;
    } req_t;

endpackage

// File: rtl/cam_req_fifo.sv
// Request queue: power-of-two depth, extra pointer bit separates full from empty.
module cam_req_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 13
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int PW = $clog2(DEPTH);

    logic [PW:0]  r_wptr;
    logic [PW:0]  r_rptr;
    logic [W-1:0] r_mem [DEPTH];
    logic         w_do_push;
    logic         w_do_pop;

    assign empty     = (r_wptr == r_rptr);
    assign full      = (r_wptr[PW] != r_rptr[PW]) && (r_wptr[PW-1:0] == r_rptr[PW-1:0]);
    // Pop is gated by empty, so a push into an empty queue is never bypassed.
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;
    assign dout      = r_mem[r_rptr[PW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + {{PW{1'b0}}, 1'b1};
            if (w_do_pop)  r_rptr <= r_rptr + {{PW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr[PW-1:0]] <= din;
    end

endmodule

// File: rtl/cam_request_scheduler.sv
// Serialises queued write/search requests onto a registered CAM port and
// returns one search result at a time with hit/miss statistics.
//
// state   | meaning
// IDLE    | wait for a queued request, pop it into the op register
// WRITE   | one-cycle cam_wen with address and data
// SEARCH  | one-cycle cam_ren with the key
// CAPTURE | register CAM hit/index, update statistics
// RESP    | hold the result until the consumer takes it
module cam_request_scheduler
    import cam_pkg::*;
#(
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_op,
    input  logic [DATA_W-1:0] req_data,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              req_ready,
    output logic              cam_wen,
    output logic              cam_ren,
    output logic [DATA_W-1:0] cam_din,
    output logic [ADDR_W-1:0] cam_addr,
    input  logic [ADDR_W-1:0] cam_dout,
    input  logic              cam_hit,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_hit,
    output logic [ADDR_W-1:0] rsp_index,
    output logic [7:0]        hit_cnt,
    output logic [7:0]        miss_cnt
);

    state_t            r_state;
    req_t              r_op;
    logic              r_rsp_hit;
    logic [ADDR_W-1:0] r_rsp_index;
    logic [7:0]        r_hit_cnt;
    logic [7:0]        r_miss_cnt;

    req_t              w_req;
    req_t              w_head;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;

    assign w_req  = '{op: req_op, data: req_data, addr: req_addr};
    assign w_push = req_valid && !w_full;
    assign w_pop  = (r_state == ST_IDLE) && !w_empty;

    cam_req_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     ($bits(req_t))
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .din   (w_req),
        .pop   (w_pop),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_op        <= '0;
            r_rsp_hit   <= 1'b0;
            r_rsp_index <= '0;
            r_hit_cnt   <= 8'd0;
            r_miss_cnt  <= 8'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty) begin
                        r_op    <= w_head;
                        r_state <= (w_head.op == OP_SEARCH) ? ST_SEARCH : ST_WRITE;
                    end
                end
                ST_WRITE:  r_state <= ST_IDLE;
                ST_SEARCH: r_state <= ST_CAPTURE;
                ST_CAPTURE: begin
                    r_rsp_hit   <= cam_hit;
                    r_rsp_index <= cam_hit ? cam_dout : '0;
                    if (cam_hit) begin
                        if (r_hit_cnt != 8'hFF) r_hit_cnt <= r_hit_cnt + 8'd1;
                    end else begin
                        if (r_miss_cnt != 8'hFF) r_miss_cnt <= r_miss_cnt + 8'd1;
                    end
                    r_state <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign req_ready = !w_full;
    assign cam_wen   = (r_state == ST_WRITE);
    assign cam_ren   = (r_state == ST_SEARCH);
    assign cam_din   = (cam_wen || cam_ren) ? r_op.data : '0;
    assign cam_addr  = cam_wen ? r_op.addr : '0;
    assign rsp_valid = (r_state == ST_RESP);
    assign rsp_hit   = r_rsp_hit;
    assign rsp_index = r_rsp_index;
    assign hit_cnt   = r_hit_cnt;
    assign miss_cnt  = r_miss_cnt;

endmodule

// File: tb/tb_cam_request_scheduler.sv
// Scoreboard bench for cam_request_scheduler with a behavioural registered CAM.
module tb_cam_request_scheduler;
    import cam_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_op;
    logic [7:0] req_data;
    logic [3:0] req_addr;
    logic       req_ready;
    logic       cam_wen;
    logic       cam_ren;
    logic [7:0] cam_din;
    logic [3:0] cam_addr;
    logic [3:0] cam_dout;
    logic       cam_hit;
    logic       rsp_valid;
    logic       rsp_ready;
    logic       rsp_hit;
    logic [3:0] rsp_index;
    logic [7:0] hit_cnt;
    logic [7:0] miss_cnt;

    always #5 clk = ~clk;

    cam_request_scheduler #(.FIFO_DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_op    (req_op),
        .req_data  (req_data),
        .req_addr  (req_addr),
        .req_ready (req_ready),
        .cam_wen   (cam_wen),
        .cam_ren   (cam_ren),
        .cam_din   (cam_din),
        .cam_addr  (cam_addr),
        .cam_dout  (cam_dout),
        .cam_hit   (cam_hit),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_hit   (rsp_hit),
        .rsp_index (rsp_index),
        .hit_cnt   (hit_cnt),
        .miss_cnt  (miss_cnt)
    );

    // Registered CAM: highest matching index wins, contents survive reset.
    logic [7:0] mem [16];
    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        cam_hit  = 1'b0;
        cam_dout = 4'd0;
    end
    always @(posedge clk) begin
        if (cam_wen) mem[cam_addr] <= cam_din;
        if (cam_ren) begin
            cam_hit  <= 1'b0;
            cam_dout <= 4'd0;
            for (int i = 0; i < 16; i++) begin
                if (mem[i] == cam_din) begin
                    cam_hit  <= 1'b1;
                    cam_dout <= 4'(i);
                end
            end
        end
    end

    int         n_cmp = 0;
    int         n_err = 0;
    logic [4:0]  exp_rsp [$];
    logic [11:0] exp_wr  [$];
    logic [7:0]  exp_ren [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_unexp(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: got a pulse, expected none", name);
    endtask

    always @(negedge clk) begin : monitor
        logic [11:0] ew;
        logic [7:0]  er;
        logic [4:0]  ers;
        if (!rst) begin
            check("strobe_exclusive", 32'(cam_wen && cam_ren), 32'd0);
            if (!cam_wen && !cam_ren) check("idle_bus_zero", {20'd0, cam_addr, cam_din}, 32'd0);
            if (cam_wen) begin
                if (exp_wr.size() == 0) fail_unexp("cam_wen_unexpected");
                else begin
                    ew = exp_wr.pop_front();
                    check("cam_wen_addr_din", {20'd0, cam_addr, cam_din}, {20'd0, ew});
                end
            end
            if (cam_ren) begin
                if (exp_ren.size() == 0) fail_unexp("cam_ren_unexpected");
                else begin
                    er = exp_ren.pop_front();
                    check("cam_ren_key", {24'd0, cam_din}, {24'd0, er});
                end
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_rsp.size() == 0) fail_unexp("rsp_unexpected");
                else begin
                    ers = exp_rsp.pop_front();
                    check("rsp_hit_index", {27'd0, rsp_hit, rsp_index}, {27'd0, ers});
                end
            end
        end
    end

    // Called and returns at a falling edge; expectations are queued at acceptance.
    task automatic send(input logic op, input logic [7:0] d, input logic [3:0] a,
                        input logic eh, input logic [3:0] ei);
        int n = 0;
        req_valid = 1'b1;
        req_op    = op;
        req_data  = d;
        req_addr  = a;
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout: req_ready 0 for 200 cycles, expected 1");
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        if (op == OP_WRITE) exp_wr.push_back({a, d});
        else begin
            exp_ren.push_back(d);
            exp_rsp.push_back({eh, ei});
        end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_drain(input int max);
        int n = 0;
        while ((exp_rsp.size() + exp_wr.size() + exp_ren.size()) != 0 && n < max) begin
            @(negedge clk);
            n++;
        end
        check("drain_pending", 32'(exp_rsp.size() + exp_wr.size() + exp_ren.size()), 32'd0);
        @(negedge clk);
    endtask

    task automatic wait_rsp_valid(input int max);
        int n = 0;
        while (!rsp_valid && n < max) begin
            @(negedge clk);
            n++;
        end
        check("rsp_valid_arrives", 32'(rsp_valid), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at 500us, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_op    = 1'b0;
        req_data  = 8'd0;
        req_addr  = 4'd0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_req_ready", 32'(req_ready), 32'd1);
        check("reset_outputs", {20'd0, rsp_valid, cam_wen, cam_ren, rsp_hit, rsp_index, cam_addr}, 32'd0);
        check("reset_cam_din", 32'(cam_din), 32'd0);
        check("reset_counters", {16'd0, hit_cnt, miss_cnt}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Write latency: cam_wen during the cycle after E+1, single pulse.
        send(OP_WRITE, 8'h5A, 4'd3, 1'b0, 4'd0);
        @(posedge clk); #1;
        check("wr_lat_wen_e1", {23'd0, cam_wen, cam_addr, 4'd0}, {23'd1, 4'd3, 4'd0});
        check("wr_lat_din_e1", 32'(cam_din), 32'h5A);
        @(posedge clk); #1;
        check("wr_lat_wen_e2", 32'(cam_wen), 32'd0);
        @(negedge clk);

        // Search latency: rsp_valid after E+3.
        send(OP_SEARCH, 8'h5A, 4'd0, 1'b1, 4'd3);
        @(posedge clk); #1;
        check("srch_lat_e1", {30'd0, rsp_valid, cam_ren}, 32'd1);
        @(posedge clk); #1;
        check("srch_lat_e2", {30'd0, rsp_valid, cam_ren}, 32'd0);
        @(posedge clk); #1;
        check("srch_lat_e3", {27'd0, rsp_valid, rsp_hit, rsp_index}, {27'd0, 1'b1, 1'b1, 4'd3});
        check("srch_hit_cnt", {16'd0, hit_cnt, miss_cnt}, {16'd0, 8'd1, 8'd0});
        @(negedge clk);
        wait_drain(50);

        // Duplicate key: highest index reported.
        send(OP_WRITE, 8'h11, 4'd2, 1'b0, 4'd0);
        send(OP_WRITE, 8'h11, 4'd9, 1'b0, 4'd0);
        send(OP_SEARCH, 8'h11, 4'd0, 1'b1, 4'd9);
        wait_drain(50);
        check("dup_hit_cnt", 32'(hit_cnt), 32'd2);

        // Absent key: miss with index 0.
        send(OP_SEARCH, 8'hC3, 4'd0, 1'b0, 4'd0);
        wait_drain(50);
        check("miss_counters", {16'd0, hit_cnt, miss_cnt}, {16'd0, 8'd2, 8'd1});

        // Back-pressure: FSM parked in RESP, queue fills after 4.
        rsp_ready = 1'b0;
        send(OP_SEARCH, 8'h5A, 4'd0, 1'b1, 4'd3);
        wait_rsp_valid(20);
        send(OP_SEARCH, 8'h11, 4'd0, 1'b1, 4'd9);
        send(OP_WRITE,  8'h77, 4'd5, 1'b0, 4'd0);
        send(OP_SEARCH, 8'h77, 4'd0, 1'b1, 4'd5);
        send(OP_SEARCH, 8'hC3, 4'd0, 1'b0, 4'd0);
        check("full_req_ready", 32'(req_ready), 32'd0);
        repeat (4) @(negedge clk);
        check("full_req_ready_hold", 32'(req_ready), 32'd0);
        check("resp_held_stable", {27'd0, rsp_valid, rsp_hit, rsp_index}, {27'd0, 1'b1, 1'b1, 4'd3});
        rsp_ready = 1'b1;
        send(OP_WRITE,  8'h22, 4'd0, 1'b0, 4'd0);
        send(OP_SEARCH, 8'h22, 4'd0, 1'b1, 4'd0);
        wait_drain(300);
        check("bp_counters", {16'd0, hit_cnt, miss_cnt}, {16'd0, 8'd6, 8'd2});

        // Miss saturation: 2 + 253 = 255, then 47 more stay at 255.
        for (int i = 0; i < 253; i++) send(OP_SEARCH, 8'hC3, 4'd0, 1'b0, 4'd0);
        wait_drain(3000);
        check("miss_at_255", {16'd0, hit_cnt, miss_cnt}, {16'd0, 8'd6, 8'd255});
        for (int i = 0; i < 47; i++) send(OP_SEARCH, 8'hC3, 4'd0, 1'b0, 4'd0);
        wait_drain(1000);
        check("miss_saturated", {16'd0, hit_cnt, miss_cnt}, {16'd0, 8'd6, 8'd255});

        // Reset in RESP with two writes queued: everything discarded.
        rsp_ready = 1'b0;
        send(OP_SEARCH, 8'h5A, 4'd0, 1'b1, 4'd3);
        wait_rsp_valid(20);
        send(OP_WRITE, 8'h99, 4'd7, 1'b0, 4'd0);
        send(OP_WRITE, 8'h99, 4'd8, 1'b0, 4'd0);
        check("pre_reset_in_resp", 32'(rsp_valid), 32'd1);
        rst = 1'b1;
        exp_rsp.delete();
        exp_wr.delete();
        exp_ren.delete();
        @(posedge clk); #1;
        check("rst_mid_outputs", {28'd0, rsp_valid, req_ready, rsp_hit, cam_wen}, {28'd0, 4'b0100});
        check("rst_mid_counters", {16'd0, hit_cnt, miss_cnt}, 32'd0);
        @(negedge clk);
        rst       = 1'b0;
        rsp_ready = 1'b1;
        repeat (20) @(negedge clk);
        check("post_rst_idle", {30'd0, rsp_valid, req_ready}, 32'd1);
        check("post_rst_counters", {16'd0, hit_cnt, miss_cnt}, 32'd0);
        check("discarded_writes", {16'd0, mem[7], mem[8]}, 32'd0);

        // CAM contents survive the scheduler reset.
        send(OP_SEARCH, 8'h5A, 4'd0, 1'b1, 4'd3);
        wait_drain(50);
        check("post_rst_hit_cnt", {16'd0, hit_cnt, miss_cnt}, {16'd0, 8'd1, 8'd0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
